cipher_byte_feeder: RTL

Upstream feeder for `aes_feedback_cipher`. It buffers a byte stream from a valid/ready source in a small FIFO, with a start-of-message flag and mode per byte. It then issues the bytes one at a time on the cipher's `in_valid`/`new_msg` strobes, waiting for the cipher's `out_ready` before issuing the next byte. It also converts each message's mode into the cipher's `enc_dec` level and flags lost handshakes with a timeout.

---
 rtl/cipher_byte_feeder_if.sv | 24 ++
 rtl/cipher_byte_feeder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cipher_byte_feeder_if.sv
// Byte-stream source and cipher strobe bundle for cipher_byte_feeder.
// master = the feeder itself; slave = the source/cipher environment around it.
interface cipher_byte_feeder_if;
  logic [7:0] s_data;
  logic       s_sof;
  logic       s_mode;
  logic       s_valid;
  logic       s_ready;
  logic       c_new_msg;
  logic       c_enc_dec;
  logic       c_in_valid;
  logic [7:0] c_in_msg;
  logic       c_out_ready;

  modport master (
    input  s_data, s_sof, s_mode, s_valid, c_out_ready,
    output s_ready, c_new_msg, c_enc_dec, c_in_valid, c_in_msg
  );

  modport slave (
    output s_data, s_sof, s_mode, s_valid, c_out_ready,
    input  s_ready, c_new_msg, c_enc_dec, c_in_valid, c_in_msg
  );
endinterface

// File: rtl/cipher_byte_feeder.sv
// Buffers a {sof, mode, data} byte stream and issues it one byte at a time to
// aes_feedback_cipher, waiting for a rising out_ready (or a timeout) per byte.
module cipher_byte_feeder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  cipher_byte_feeder_if.master    bus,
  input  logic                    err_clr,
  output logic                    timeout_err,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] PONE  = 1;
  localparam logic [CW-1:0] CONE  = 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [WW-1:0] WONE  = 1;
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

  typedef struct packed {
    logic       sof;
    logic       mode;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, NEWMSG, SEND, WAIT} state_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  state_t        state;
  logic [WW-1:0] wcnt;
  logic          or_q;
  logic          rise;
  logic          push;
  logic          pop;

  assign bus.s_ready = (fifo_count != FULL);
  assign push        = bus.s_valid && bus.s_ready;
  assign pop         = (state == SEND);
  assign head        = mem[rd_ptr];
  assign rise        = bus.c_out_ready & ~or_q;
  assign busy        = (state != IDLE) || (fifo_count != '0);

  // Storage carries no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.s_sof, bus.s_mode, bus.s_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PONE;
      if (pop)  rd_ptr <= rd_ptr + PONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CONE;
        2'b01:   fifo_count <= fifo_count - CONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      bus.c_new_msg  <= 1'b0;
      bus.c_in_valid <= 1'b0;
      bus.c_in_msg   <= '0;
      bus.c_enc_dec  <= 1'b1;
      timeout_err    <= 1'b0;
      or_q           <= 1'b0;
      wcnt           <= '0;
    end else begin
      or_q <= bus.c_out_ready;
      // A timeout set later in this block overrides a same-cycle clear.
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_count != '0) begin
            if (head.sof) begin
              state         <= NEWMSG;
              bus.c_new_msg <= 1'b1;
              bus.c_enc_dec <= head.mode;
            end else begin
              state          <= SEND;
              bus.c_in_valid <= 1'b1;
              bus.c_in_msg   <= head.data;
            end
          end
        end
        NEWMSG: begin
          state          <= SEND;
          bus.c_new_msg  <= 1'b0;
          bus.c_in_valid <= 1'b1;
          bus.c_in_msg   <= head.data;
        end
        SEND: begin
          bus.c_in_valid <= 1'b0;
          wcnt           <= '0;
          state          <= rise ? IDLE : WAIT;
        end
        WAIT: begin
          if (rise) begin
            state <= IDLE;
          end else if (wcnt == WLAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wcnt <= wcnt + WONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
